alu_share_arbiter: RTL
======================

Name: alu_share_arbiter

Overview:
- Shares one combinational ALU between two requesters: port 0 is the core execute path, port 1 is the auxiliary address/compare unit.
- Round-robin arbitration with a valid/ready request handshake on each port.
- Two-stage pipeline: an issue register drives the ALU, and a response register captures its result.
- The ALU is instantiated at the same level as this block. This block only drives its operands and op code and samples its result.

Parameters:
- DATA_W, 32, operand/result width; must match the ALU.
- OP_W, 4, ALU op-code width; codes come from alu_pkg.
- RR_INIT, 0, requester that holds priority after reset.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_valid_i  in  [1:0]  per-requester request valid.
- req_ready_o  out  [1:0]  per-requester accept; a transfer occurs when valid&ready at an edge.
- req_op_i  in  [1:0][OP_W-1:0]  per-requester ALU op code.
- req_a_i  in  [1:0][DATA_W-1:0]  per-requester operand1.
- req_b_i  in  [1:0][DATA_W-1:0]  per-requester operand2.
- alu_operand1_o  out  DATA_W  to ALU operand1.
- alu_operand2_o  out  DATA_W  to ALU operand2.
- alu_op_o  out  OP_W  to ALU op select.
- alu_data_i  in  DATA_W  combinational ALU result.
- rsp_valid_o  out  [1:0]  one-hot: result valid for that requester.
- rsp_ready_i  in  [1:0]  per-requester result accept.
- rsp_data_o  out  DATA_W  result, shared by both ports; meaningful only under rsp_valid_o.

Behaviour:
- State:
  - iss_v, iss_id, iss_op, iss_a, iss_b (issue stage).
  - rsp_v, rsp_id, rsp_data (response stage).
  - rr_ptr (requester with priority).
- Reset (async assert):
  - iss_v=0, rsp_v=0, rr_ptr=RR_INIT, all data regs 0.
  - Outputs: req_ready_o=00, rsp_valid_o=00, rsp_data_o=0, alu_* = 0.
  - Any in-flight operation is discarded.
  - Deassertion is consumed synchronously; the first acceptance is possible at the first edge after release.
- Stall chain:
  - rsp_free = !rsp_v | rsp_ready_i[rsp_id].
  - iss_adv = iss_v & rsp_free.
  - iss_free = !iss_v | iss_adv.
- Arbitration (combinational):
  - If only one req_valid_i bit is set, that requester wins.
  - If both are set, rr_ptr wins.
  - req_ready_o[w] = iss_free for the winner only; the loser sees 0.
  - req_ready_o does not depend on req_valid_i of the same port; it may depend on the other port's valid.
- rr_ptr update:
  - On every accepted request, rr_ptr <= ~winner.
  - Two continuously requesting ports therefore alternate 0,1,0,1.
  - rr_ptr is unchanged when nothing is accepted.
- Issue:
  - On acceptance, iss_* load the winner's op/a/b/id and iss_v <= 1.
  - If iss_adv occurs with no acceptance, iss_v <= 0.
- ALU drive: alu_operand1_o=iss_a, alu_operand2_o=iss_b, alu_op_o=iss_op. These hold stable while iss_v and stalled; they are 0 when !iss_v.
- Response:
  - On iss_adv: rsp_data <= alu_data_i, rsp_id <= iss_id, rsp_v <= 1.
  - If rsp_v is drained with no iss_adv: rsp_v <= 0.
  - rsp_valid_o = rsp_v ? (1<<rsp_id) : 00.
  - rsp_data_o holds stable until the handshake completes.
- Latency:
  - Request accepted at edge N gives rsp_valid_o at cycle N+2 when there is no back-pressure.
  - Throughput is 1 operation/cycle with full overlap (accept, issue and drain in the same cycle).
- Ordering: results return in acceptance order. A stalled response for one port blocks the other port (single in-order pipe, no bypass).
- The op code is not interpreted here. Illegal codes pass through, and the ALU returns 0 for them.

Decomposition:
- alu_pkg holds:
  - the op-code constants, as enum alu_op_e (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, LUI), replacing the global macro file;
  - DATA_W/OP_W defaults;
  - typedef alu_req_t {op, a, b}.
- One sub-module: rr_arb2, a 2-input round-robin arbiter containing rr_ptr, with inputs req[1:0], advance, and output grant[1:0].
- The pipeline registers stay in the top.

Test Plan:
1. Reset: hold rst_ni=0 with req_valid_i=11 → req_ready_o=00, rsp_valid_o=00, alu_op_o=0. Release → port 0 is granted first.
2. Single request, ADD: port 0 sends ADD a=5, b=7 at edge N → alu_operand1_o=5 in cycle N+1; rsp_valid_o=01 and rsp_data_o=12 at N+2.
3. Contention: both ports valid for 4 cycles, SUB 10-3 on port 0 and SLT -1<1 on port 1, rsp_ready_i=11 → grants alternate 0,1,0,1; responses 7, 1, 7, 1 with rsp_valid_o 01, 10, 01, 10.
4. Back-pressure: rsp_ready_i=00 for 3 cycles with continuous port 0 traffic → the response holds its value, the issue stage fills, req_ready_o drops to 00 after 2 accepts; releasing rsp_ready_i=01 resumes with no loss and no duplication.
5. Cross-port blocking: port 1 response stalled (rsp_ready_i=01), port 0 requesting → port 0 gets at most one accept into the issue stage, then stalls until rsp_ready_i[1]=1.
6. Mid-operation reset: assert rst_ni=0 while iss_v=1 and rsp_v=1 → all outputs are 0 immediately (async); after release, rr_ptr=RR_INIT and no stale response appears.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU op-code enum, default widths and request bundle type
package alu_pkg;

  localparam int unsigned ALU_DATA_W = 32;
  localparam int unsigned ALU_OP_W   = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    ADD  = 4'd0,
    SUB  = 4'd1,
    SLL  = 4'd2,
    SLT  = 4'd3,
    SLTU = 4'd4,
    XOR  = 4'd5,
    SRL  = 4'd6,
    SRA  = 4'd7,
    OR   = 4'd8,
    AND  = 4'd9,
    LUI  = 4'd10
  } alu_op_e;

  typedef struct packed {
    logic [ALU_OP_W-1:0]   op;
    logic [ALU_DATA_W-1:0] a;
    logic [ALU_DATA_W-1:0] b;
  } alu_req_t;

endpackage

// File: rtl/alu_share_arbiter_rr_arb2.sv
// rtl/alu_share_arbiter_rr_arb2.sv - two-input round-robin arbiter holding the priority pointer
// Ports:
//   clk_i, rst_ni  clock, async active-low reset
//   req_i[1:0]     request valid per requester
//   advance_i      downstream can take a request this cycle
//   grant_o[1:0]   port would be accepted if it requests; independent of its own req bit
module rr_arb2
  import alu_pkg::*;
#(
  parameter bit RR_INIT = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] grant_o
);

  logic       rr_ptr_q, rr_ptr_d;
  logic [1:0] win;

  // A port is granted unless the other port also requests and holds priority.
  assign grant_o[0] = ~req_i[1] | ~rr_ptr_q;
  assign grant_o[1] = ~req_i[0] |  rr_ptr_q;
  assign win        = req_i & grant_o;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (advance_i && (win != 2'b00)) begin
      rr_ptr_d = ~win[1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= RR_INIT;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - shares one combinational ALU between two requesters, two-stage in-order pipe
// Ports:
//   clk_i, rst_ni                      clock, async active-low reset
//   req_valid_i/req_ready_o [1:0]      request handshake per requester
//   req_op_i, req_a_i, req_b_i         per-requester op code and operands
//   alu_operand1_o/2_o, alu_op_o       drive to the external ALU (zero when idle)
//   alu_data_i                         combinational ALU result
//   rsp_valid_o [1:0] (one-hot)        result valid for that requester
//   rsp_ready_i [1:0]                  result accept per requester
//   rsp_data_o                         shared result bus
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W  = ALU_DATA_W,
  parameter int unsigned OP_W    = ALU_OP_W,
  parameter int unsigned RR_INIT = 0
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [1:0]                 req_valid_i,
  output logic [1:0]                 req_ready_o,
  input  logic [1:0][OP_W-1:0]       req_op_i,
  input  logic [1:0][DATA_W-1:0]     req_a_i,
  input  logic [1:0][DATA_W-1:0]     req_b_i,
  output logic [DATA_W-1:0]          alu_operand1_o,
  output logic [DATA_W-1:0]          alu_operand2_o,
  output logic [OP_W-1:0]            alu_op_o,
  input  logic [DATA_W-1:0]          alu_data_i,
  output logic [1:0]                 rsp_valid_o,
  input  logic [1:0]                 rsp_ready_i,
  output logic [DATA_W-1:0]          rsp_data_o
);

  logic              iss_v_q, iss_id_q;
  logic [OP_W-1:0]   iss_op_q;
  logic [DATA_W-1:0] iss_a_q, iss_b_q;
  logic              rsp_v_q, rsp_id_q;
  logic [DATA_W-1:0] rsp_data_q;

  logic       rsp_free, iss_adv, iss_free;
  logic [1:0] grant, acc;
  logic       acc_any, acc_id;

  assign rsp_free = ~rsp_v_q | rsp_ready_i[rsp_id_q];
  assign iss_adv  = iss_v_q & rsp_free;
  assign iss_free = ~iss_v_q | iss_adv;

  rr_arb2 #(
    .RR_INIT (RR_INIT != 0)
  ) u_arb (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (req_valid_i),
    .advance_i (iss_free),
    .grant_o   (grant)
  );

  // Ready is held low while reset is asserted; the empty pipe would otherwise look free.
  assign req_ready_o = grant & {2{iss_free & rst_ni}};
  assign acc         = req_valid_i & req_ready_o;
  assign acc_any     = |acc;
  assign acc_id      = acc[1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      iss_v_q  <= 1'b0;
      iss_id_q <= 1'b0;
      iss_op_q <= '0;
      iss_a_q  <= '0;
      iss_b_q  <= '0;
    end else if (acc_any) begin
      iss_v_q  <= 1'b1;
      iss_id_q <= acc_id;
      iss_op_q <= req_op_i[acc_id];
      iss_a_q  <= req_a_i[acc_id];
      iss_b_q  <= req_b_i[acc_id];
    end else if (iss_adv) begin
      iss_v_q  <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_v_q    <= 1'b0;
      rsp_id_q   <= 1'b0;
      rsp_data_q <= '0;
    end else if (iss_adv) begin
      rsp_v_q    <= 1'b1;
      rsp_id_q   <= iss_id_q;
      rsp_data_q <= alu_data_i;
    end else if (rsp_free) begin
      rsp_v_q    <= 1'b0;
    end
  end

  assign alu_operand1_o = iss_v_q ? iss_a_q  : '0;
  assign alu_operand2_o = iss_v_q ? iss_b_q  : '0;
  assign alu_op_o       = iss_v_q ? iss_op_q : '0;

  assign rsp_valid_o = rsp_v_q ? (rsp_id_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_data_o  = rsp_data_q;

endmodule
